// File: rtl/ibuf_pkg.sv
// Shared types and width helpers for the instruction prefetch queue.
// Provides byte lane type, flush FSM encoding and clog2-based widths.
package ibuf_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Index width for n entries (at least one bit).
    function automatic int idxW(int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Counter width able to hold 0..n inclusive.
    function automatic int cntW(int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/ibuf_prefetch_queue_if.sv
// Fetch bus and decoder window bundle of the instruction prefetch queue.
// master: queue side (oMemReq/oBuf/oAvail/oAck out); slave: environment.
interface ibuf_prefetch_queue_if
    import ibuf_pkg::*;
#(
    parameter int FETCH_BYTES = 8,
    parameter int OUT_BYTES   = 6
);

    logic                          oMemReq;
    logic                          iFWr;
    logic [BYTE_W*FETCH_BYTES-1:0] iFData;
    logic [BYTE_W*OUT_BYTES-1:0]   oBuf;
    logic [cntW(OUT_BYTES)-1:0]    oAvail;
    logic                          iConsume;
    logic [cntW(OUT_BYTES)-1:0]    iConsumeCnt;
    logic                          oAck;

    modport master (
        output oMemReq, oBuf, oAvail, oAck,
        input  iFWr, iFData, iConsume, iConsumeCnt
    );

    modport slave (
        input  oMemReq, oBuf, oAvail, oAck,
        output iFWr, iFData, iConsume, iConsumeCnt
    );

endinterface

// File: rtl/ibuf_byte_window.sv
// Combinational rotator: OUT_BYTES bytes from the circular array at iRdPtr.
// Ports: iMem (flat array), iRdPtr (byte ptr), iAvail (valid lanes), oBuf.
module ibuf_byte_window
    import ibuf_pkg::*;
#(
    parameter int CAP       = 32,
    parameter int OUT_BYTES = 6
) (
    input  logic [BYTE_W*CAP-1:0]       iMem,
    input  logic [idxW(CAP)-1:0]        iRdPtr,
    input  logic [cntW(OUT_BYTES)-1:0]  iAvail,
    output logic [BYTE_W*OUT_BYTES-1:0] oBuf
);

    localparam int RW = idxW(CAP);

    logic [RW-1:0] idx;
    byte_t         lane;

    always_comb begin
        oBuf = '0;
        idx  = '0;
        lane = '0;
        for (int k = 0; k < OUT_BYTES; k++) begin
            // Index wraps naturally at the array size.
            idx  = iRdPtr + RW'(k);
            lane = iMem[int'(idx)*BYTE_W +: BYTE_W];
            if (k < int'(iAvail)) begin
                oBuf[k*BYTE_W +: BYTE_W] = lane;
            end
        end
    end

endmodule

// File: rtl/ibuf_prefetch_queue.sv
// Circular instruction byte queue between fetch bus and decoder.
// Ports: iClk/iRst, iJumped/iJumpOfs flush, bus (fetch+window), oErr, oLevel.
module ibuf_prefetch_queue
    import ibuf_pkg::*;
#(
    parameter int FETCH_BYTES = 8,
    parameter int DEPTH_WORDS = 4,
    parameter int OUT_BYTES   = 6,
    parameter int MAX_OUT     = 2
) (
    input  logic                                    iClk,
    input  logic                                    iRst,
    input  logic                                    iJumped,
    input  logic [idxW(FETCH_BYTES)-1:0]            iJumpOfs,
    ibuf_prefetch_queue_if.master                   bus,
    output logic                                    oErr,
    output logic [cntW(FETCH_BYTES*DEPTH_WORDS)-1:0] oLevel
);

    localparam int CAP = FETCH_BYTES * DEPTH_WORDS;
    localparam int WPW = idxW(DEPTH_WORDS);
    localparam int RPW = idxW(CAP);
    localparam int LVW = cntW(CAP);
    localparam int AVW = cntW(OUT_BYTES);
    localparam int OFW = idxW(FETCH_BYTES);
    localparam int OSW = cntW(MAX_OUT);

    state_e stateQ, stateN;

    logic [BYTE_W*CAP-1:0] memQ;
    logic [WPW-1:0]        wrPtrQ;
    logic [RPW-1:0]        rdPtrQ;
    logic [LVW-1:0]        levelQ;
    logic [OSW-1:0]        outQ, outN;
    logic [OSW-1:0]        discQ, discN, discJ;
    logic [OFW-1:0]        skipQ;
    logic                  reqQ, ackQ, errQ;

    logic [LVW-1:0] freeB;
    logic [AVW-1:0] avail;
    logic [AVW-1:0] cnt;
    logic           creditOk;
    logic           consOk, consBad;
    logic           fwrDec;
    logic           reqGo, wrOk, fwrBad, drainDrop;
    logic [LVW-1:0] wrAdd, consSub;
    logic [RPW-1:0] rdAdd;

    assign freeB = LVW'(CAP) - levelQ;
    assign avail = (levelQ > LVW'(OUT_BYTES)) ? AVW'(OUT_BYTES)
                                              : AVW'(levelQ);
    assign cnt   = bus.iConsumeCnt;

    // Credit reserves room for every outstanding word plus the new one.
    assign creditOk = (int'(outQ) < MAX_OUT) &&
                      (int'(freeB) >= (int'(outQ) + 1) * FETCH_BYTES);

    assign consOk  = bus.iConsume && !iJumped && (cnt != '0) &&
                     (int'(cnt) <= OUT_BYTES) && (cnt <= avail);
    assign consBad = bus.iConsume && !iJumped && !consOk;

    // Any returning word retires one outstanding request.
    assign fwrDec = bus.iFWr && (outQ != '0);

    // Stale words still owed after a jump; a same-cycle return is dropped.
    assign discJ = outQ - (fwrDec ? OSW'(1) : OSW'(0));

    // State register.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stateQ <= RUN;
        end else begin
            stateQ <= stateN;
        end
    end

    // Next-state logic.
    always_comb begin
        stateN = stateQ;
        if (iJumped) begin
            stateN = (discJ != '0) ? DRAIN : RUN;
        end else if (stateQ == DRAIN && drainDrop &&
                     discQ == OSW'(1)) begin
            stateN = RUN;
        end
    end

    // State-dependent controls.
    always_comb begin
        reqGo     = 1'b0;
        wrOk      = 1'b0;
        fwrBad    = 1'b0;
        drainDrop = 1'b0;
        unique case (stateQ)
            RUN: begin
                reqGo  = creditOk && !iJumped;
                wrOk   = bus.iFWr && !iJumped && (outQ != '0);
                fwrBad = bus.iFWr && !iJumped && (outQ == '0);
            end
            DRAIN: begin
                drainDrop = bus.iFWr && !iJumped;
            end
        endcase
    end

    always_comb begin
        outN = outQ;
        if (reqGo) outN = outN + OSW'(1);
        if (fwrDec) outN = outN - OSW'(1);
    end

    always_comb begin
        discN = discQ;
        if (iJumped) begin
            discN = discJ;
        end else if (drainDrop && discQ != '0) begin
            discN = discQ - OSW'(1);
        end
    end

    // First word after a jump drops its leading skip bytes.
    assign wrAdd   = wrOk ? (LVW'(FETCH_BYTES) - LVW'(skipQ)) : '0;
    assign consSub = consOk ? LVW'(cnt) : '0;
    assign rdAdd   = (wrOk ? RPW'(skipQ) : RPW'(0)) +
                     (consOk ? RPW'(cnt) : RPW'(0));

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            levelQ <= '0;
            outQ   <= '0;
            discQ  <= '0;
            skipQ  <= '0;
            reqQ   <= 1'b0;
            ackQ   <= 1'b0;
            errQ   <= 1'b0;
        end else begin
            reqQ  <= reqGo;
            ackQ  <= consOk;
            outQ  <= outN;
            discQ <= discN;
            if (consBad || fwrBad) errQ <= 1'b1;
            if (iJumped) begin
                wrPtrQ <= '0;
                rdPtrQ <= '0;
                levelQ <= '0;
                skipQ  <= iJumpOfs;
            end else begin
                rdPtrQ <= rdPtrQ + rdAdd;
                levelQ <= levelQ + wrAdd - consSub;
                if (wrOk) begin
                    wrPtrQ <= wrPtrQ + WPW'(1);
                    skipQ  <= '0;
                end
            end
        end
    end

    // Storage needs no reset; unwritten bytes are never inside the level.
    always_ff @(posedge iClk) begin
        if (wrOk) begin
            memQ[int'(wrPtrQ)*BYTE_W*FETCH_BYTES +: BYTE_W*FETCH_BYTES]
                <= bus.iFData;
        end
    end

    ibuf_byte_window #(
        .CAP       (CAP),
        .OUT_BYTES (OUT_BYTES)
    ) uWindow (
        .iMem   (memQ),
        .iRdPtr (rdPtrQ),
        .iAvail (avail),
        .oBuf   (bus.oBuf)
    );

    assign bus.oMemReq = reqQ;
    assign bus.oAvail  = avail;
    assign bus.oAck    = ackQ;
    assign oErr        = errQ;
    assign oLevel      = levelQ;

endmodule

// File: tb/tb_ibuf_prefetch_queue.sv
// Directed self-checking bench for ibuf_prefetch_queue.
// Drives fetch returns, consumes and jumps; checks window, level, flags.
module tb_ibuf_prefetch_queue;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iJumped = 1'b0;
    logic [2:0] iJumpOfs = '0;
    logic       oErr;
    logic [5:0] oLevel;

    int nVec = 0;
    int nErr = 0;
    int wIdx = 0;
    bit respond = 1'b0;
    int consumed;
    logic [63:0] expW;
    logic [63:0] junk = 64'hDEADBEEFCAFEF00D;

    ibuf_prefetch_queue_if #(.FETCH_BYTES(8), .OUT_BYTES(6)) bus ();

    ibuf_prefetch_queue #(
        .FETCH_BYTES (8),
        .DEPTH_WORDS (4),
        .OUT_BYTES   (6),
        .MAX_OUT     (2)
    ) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iJumped  (iJumped),
        .iJumpOfs (iJumpOfs),
        .bus      (bus),
        .oErr     (oErr),
        .oLevel   (oLevel)
    );

    always #5 iClk = ~iClk;

    function automatic logic [63:0] mkWord(int n);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[k*8 +: 8] = 8'(n*8 + k);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; clear pulses; memory model answers a visible
    // request in the same cycle it is seen.
    task automatic step();
        @(posedge iClk);
        #1;
        iJumped         = 1'b0;
        bus.iConsume    = 1'b0;
        bus.iConsumeCnt = '0;
        bus.iFWr        = 1'b0;
        bus.iFData      = '0;
        if (respond && bus.oMemReq) begin
            bus.iFWr   = 1'b1;
            bus.iFData = mkWord(wIdx);
            wIdx++;
        end
    endtask

    task automatic chkRst(input string tag);
        chk({tag, "_req"}, bus.oMemReq, 0);
        chk({tag, "_avail"}, bus.oAvail, 0);
        chk({tag, "_buf"}, bus.oBuf, 0);
        chk({tag, "_ack"}, bus.oAck, 0);
        chk({tag, "_err"}, oErr, 0);
        chk({tag, "_level"}, oLevel, 0);
    endtask

    initial begin
        bus.iFWr        = 1'b0;
        bus.iFData      = '0;
        bus.iConsume    = 1'b0;
        bus.iConsumeCnt = '0;

        step();
        step();
        chkRst("reset");

        // Cold start with a one-cycle memory.
        iRst    = 1'b0;
        respond = 1'b1;
        wIdx    = 0;
        step();
        chk("first_req", bus.oMemReq, 1);
        step();
        chk("w0_avail", bus.oAvail, 6);
        chk("w0_buf", bus.oBuf, 64'h050403020100);
        chk("w0_level", oLevel, 8);

        // Consume 3 together with the second return.
        bus.iConsume    = 1'b1;
        bus.iConsumeCnt = 4'd3;
        step();
        chk("wc_level", oLevel, 13);
        chk("wc_byte0", bus.oBuf[7:0], 8'h03);
        chk("wc_ack", bus.oAck, 1);
        step();
        step();
        step();
        chk("full_level", oLevel, 29);
        chk("full_noreq", bus.oMemReq, 0);

        // Drain window with memory silent so two requests pile up.
        respond = 1'b0;
        repeat (4) begin
            bus.iConsume    = 1'b1;
            bus.iConsumeCnt = 4'd6;
            step();
        end
        chk("pre_jump_req", bus.oMemReq, 1);
        chk("pre_jump_avail", bus.oAvail, 5);
        chk("pre_jump_buf", bus.oBuf, 64'h001F1E1D1C1B);
        chk("pre_jump_ack", bus.oAck, 1);

        // Jump with two stale fetches in flight.
        iJumped  = 1'b1;
        iJumpOfs = 3'd5;
        step();
        chk("jmp_level", oLevel, 0);
        chk("jmp_buf", bus.oBuf, 0);
        chk("jmp_ack", bus.oAck, 0);
        chk("jmp_req", bus.oMemReq, 0);
        bus.iFWr   = 1'b1;
        bus.iFData = junk;
        step();
        chk("drop1_level", oLevel, 0);
        bus.iFWr   = 1'b1;
        bus.iFData = junk;
        step();
        chk("drop2_req", bus.oMemReq, 0);
        step();
        chk("run_req", bus.oMemReq, 1);
        bus.iFWr   = 1'b1;
        bus.iFData = mkWord(2);
        step();
        chk("skip_avail", bus.oAvail, 3);
        chk("skip_buf", bus.oBuf, 64'h171615);
        chk("skip_level", oLevel, 3);

        // Jump coinciding with the only outstanding return.
        iJumped    = 1'b1;
        iJumpOfs   = 3'd0;
        bus.iFWr   = 1'b1;
        bus.iFData = junk;
        step();
        chk("jw_level", oLevel, 0);
        chk("jw_req", bus.oMemReq, 0);
        step();
        chk("jw_run_req", bus.oMemReq, 1);

        // Set up two valid bytes, then an oversize consume.
        iJumped    = 1'b1;
        iJumpOfs   = 3'd6;
        bus.iFWr   = 1'b1;
        bus.iFData = junk;
        step();
        chk("j6_req", bus.oMemReq, 0);
        step();
        chk("j6_run_req", bus.oMemReq, 1);
        bus.iFWr   = 1'b1;
        bus.iFData = mkWord(5);
        step();
        chk("two_avail", bus.oAvail, 2);
        chk("two_buf", bus.oBuf, 64'h2F2E);
        chk("two_err", oErr, 0);
        bus.iConsume    = 1'b1;
        bus.iConsumeCnt = 4'd4;
        step();
        chk("bad_err", oErr, 1);
        chk("bad_ack", bus.oAck, 0);
        chk("bad_level", oLevel, 2);

        // Enter DRAIN, then reset asynchronously mid-drain.
        iJumped  = 1'b1;
        iJumpOfs = 3'd0;
        step();
        chk("dr_req", bus.oMemReq, 0);
        chk("dr_level", oLevel, 0);
        bus.iFWr   = 1'b1;
        bus.iFData = junk;
        step();
        chk("dr2_req", bus.oMemReq, 0);
        chk("dr2_err", oErr, 1);
        #2;
        iRst = 1'b1;
        #1;
        chkRst("async_rst");
        @(posedge iClk);
        #1;
        iRst    = 1'b0;
        respond = 1'b1;
        wIdx    = 0;
        step();
        chk("post_rst_req", bus.oMemReq, 1);

        // Stream through the queue five times over.
        consumed = 0;
        for (int c = 0; c < 400 && consumed < 160; c++) begin
            if (bus.oAvail >= 4'd4) begin
                expW = '0;
                for (int k = 0; k < 4; k++)
                    expW[k*8 +: 8] = 8'(consumed + k);
                chk("stream", 64'(bus.oBuf[31:0]), expW);
                bus.iConsume    = 1'b1;
                bus.iConsumeCnt = 4'd4;
                consumed += 4;
            end
            step();
        end
        chk("stream_done", 64'(consumed >= 160), 1);
        chk("stream_err", oErr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
